uart_rx_engine: RTL and testbench

//  Serial receive engine feeding the UART RX buffer/register file (RXBUF, STATUS, rx interrupt).

---
 rtl/uart_rx_engine.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_engine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises rxd, detects start bits, oversamples and deserialises frames.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting per bit when brgh = 0.
module uart_rx_engine #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       brgh_i,
    input  logic [1:0] pdsel_i,
    input  logic       stsel_i,
    input  logic       tick_i,
    input  logic       rxd_i,
    output logic [8:0] rx_data_o,
    output logic       rx_perr_o,
    output logic       rx_ferr_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       overrun_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                 state, next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxd_s;
    logic                   tick;
    logic                   brgh_l, stsel_l;
    logic [1:0]             pdsel_l;
    logic [3:0]             cnt, cnt_max, sample_at, data_last, bit_idx;
    logic [8:0]             shreg;
    logic                   par, ferr_acc, armed;
    logic                   has_parity, start_det, take, bit_val;
    logic                   frame_done, done_perr, done_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '1;
        else        sync <= {sync[SYNC_STAGES-2:0], rxd_i};
    end

    assign rxd_s      = sync[SYNC_STAGES-1];
    assign tick       = en_i & tick_i;
    assign cnt_max    = brgh_l ? 4'd3 : 4'd15;
    assign data_last  = (pdsel_l == 2'b11) ? 4'd8 : 4'd7;
    assign has_parity = (pdsel_l == 2'b01) || (pdsel_l == 2'b10);

`ifdef UART_RX_MAJORITY_EN
    logic s_early, s_mid;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Samples at M-1 and M feed the vote that is decided at M+1.
    always_ff @(posedge clk) begin
        if (tick && !brgh_l && cnt == 4'd6) s_early <= rxd_s;
        if (tick && !brgh_l && cnt == 4'd7) s_mid   <= rxd_s;
    end

    assign sample_at = brgh_l ? 4'd1 : 4'd8;
    assign bit_val   = brgh_l ? rxd_s : maj3(s_early, s_mid, rxd_s);
`else
    assign sample_at = brgh_l ? 4'd1 : 4'd7;
    assign bit_val   = rxd_s;
`endif

    // armed gates start detection so a held-low line cannot retrigger after a break.
    assign start_det = tick && (state == IDLE) && !rxd_s && armed;
    assign take      = tick && (state != IDLE) && (cnt == sample_at);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        if (!en_i) begin
            next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_det) next = START;
                START:   if (take) next = bit_val ? IDLE : DATA;
                DATA:    if (take && bit_idx == data_last) next = has_parity ? PARITY : STOP1;
                PARITY:  if (take) next = STOP1;
                STOP1:   if (take) next = stsel_l ? STOP2 : IDLE;
                STOP2:   if (take) next = IDLE;
                default: next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o     = (state != IDLE);
        frame_done = take && ((state == STOP1 && !stsel_l) || state == STOP2);
        done_ferr  = !bit_val || (state == STOP2 && ferr_acc);
        done_perr  = has_parity && ((^{shreg[7:0], par}) != (pdsel_l == 2'b10));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brgh_l   <= 1'b0;
            pdsel_l  <= 2'b00;
            stsel_l  <= 1'b0;
            cnt      <= 4'd0;
            bit_idx  <= 4'd0;
            shreg    <= 9'd0;
            par      <= 1'b0;
            ferr_acc <= 1'b0;
            armed    <= 1'b0;
        end else begin
            if (rxd_s) armed <= 1'b1;
            if (frame_done && !bit_val) armed <= 1'b0;
            if (start_det) begin
                brgh_l   <= brgh_i;
                pdsel_l  <= pdsel_i;
                stsel_l  <= stsel_i;
                cnt      <= 4'd0;
                bit_idx  <= 4'd0;
                shreg    <= 9'd0;
                ferr_acc <= 1'b0;
            end else if (tick && state != IDLE) begin
                cnt <= (cnt == cnt_max) ? 4'd0 : cnt + 4'd1;
                if (take) begin
                    case (state)
                        DATA: begin
                            shreg[bit_idx] <= bit_val;
                            bit_idx        <= bit_idx + 4'd1;
                        end
                        PARITY:  par      <= bit_val;
                        STOP1:   ferr_acc <= !bit_val;
                        default: ;
                    endcase
                end
            end
        end
    end

    // One-entry output register; a completed frame is dropped while it is occupied and stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_o  <= 9'd0;
            rx_perr_o  <= 1'b0;
            rx_ferr_o  <= 1'b0;
            rx_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (!en_i) begin
                rx_valid_o <= 1'b0;
            end else if (frame_done) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o  <= shreg;
                    rx_perr_o  <= done_perr;
                    rx_ferr_o  <= done_ferr;
                    rx_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Randomised self-checking bench for uart_rx_engine against a frame-level reference model.
module tb_uart_rx_engine;

    logic       clk, rst_n, en, brgh, stsel, tick, rxd, ready;
    logic [1:0] pdsel;
    logic [8:0] rx_data;
    logic       rx_perr, rx_ferr, rx_valid, overrun, busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ovr_cnt  = 0;
    int          rd       = 0;
    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];

`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 153;
`else
    localparam int LAT = 152;
`endif

    uart_rx_engine #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .brgh_i(brgh), .pdsel_i(pdsel),
        .stsel_i(stsel), .tick_i(tick), .rxd_i(rxd), .rx_data_o(rx_data),
        .rx_perr_o(rx_perr), .rx_ferr_o(rx_ferr), .rx_valid_o(rx_valid),
        .rx_ready_i(ready), .overrun_o(overrun), .busy_o(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample strobe: one clock high out of every three.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && ready) got_q.push_back({rx_data, rx_perr, rx_ferr});
            if (overrun) ovr_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [10:0] model(input logic [1:0] pd, input logic [8:0] w,
                                          input logic pb, input logic s1, input logic s2,
                                          input logic st);
        logic [8:0] d;
        logic       pe, fe;
        int         ones;
        d    = (pd == 2'b11) ? w : {1'b0, w[7:0]};
        ones = $countones(w[7:0]) + int'(pb);
        pe   = 1'b0;
        if (pd == 2'b01) pe = (ones % 2) != 0;
        if (pd == 2'b10) pe = (ones % 2) != 1;
        fe   = !s1 || (st && !s2);
        return {d, pe, fe};
    endfunction

    task automatic wait_tick();
        do @(posedge clk); while (tick !== 1'b1);
    endtask

    task automatic hold_line(input logic v, input int n);
        rxd = v;
        repeat (n) begin
            wait_tick();
            #1;
        end
    endtask

    task automatic send_frame(input logic br, input logic [1:0] pd, input logic st,
                              input logic [8:0] w, input logic pb, input logic s1,
                              input logic s2, input int gap, input logic scramble,
                              input int glitch_t);
        logic bits[13];
        int   n, nb, dbits;
        n     = br ? 4 : 16;
        dbits = (pd == 2'b11) ? 9 : 8;
        brgh  = br;
        pdsel = pd;
        stsel = st;
        bits[0] = 1'b0;
        for (int i = 0; i < dbits; i++) bits[1+i] = w[i];
        nb = 1 + dbits;
        if (pd == 2'b01 || pd == 2'b10) begin
            bits[nb] = pb;
            nb++;
        end
        bits[nb] = s1;
        nb++;
        if (st) begin
            bits[nb] = s2;
            nb++;
        end
        exp_q.push_back(model(pd, w, pb, s1, s2, st));
        for (int t = 0; t < nb * n; t++) begin
            rxd = bits[t/n];
            if (t == glitch_t) rxd = 1'b0;
            wait_tick();
            #1;
            if (scramble && t == 0) begin
                brgh  = 1'($urandom);
                pdsel = 2'($urandom);
                stsel = 1'($urandom);
            end
        end
        hold_line(1'b1, gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        en = 1'b1; ready = 1'b1; rxd = 1'b1; brgh = 1'b0; pdsel = 2'b00; stsel = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 9'h000) $display("FAIL reset_data got %h want 000", rx_data); else n_pass++;
        n_checks++; if ({rx_perr, rx_ferr} !== 2'b00) $display("FAIL reset_flags got %b want 00", {rx_perr, rx_ferr}); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else n_pass++;
        rst_n = 1'b1;
        hold_line(1'b1, 4);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_idle_valid got %b want 0", rx_valid); else n_pass++;
    endtask

    task automatic test_timing();
        logic       bits[10];
        logic [8:0] w;
        w = 9'h0A5;
        brgh = 1'b0; pdsel = 2'b00; stsel = 1'b0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = w[i];
        bits[9] = 1'b1;
        exp_q.push_back(model(2'b00, w, 1'b0, 1'b1, 1'b1, 1'b0));
        for (int t = 0; t < 160; t++) begin
            rxd = bits[t/16];
            wait_tick();
            #1;
            if (t == LAT - 1) begin
                n_checks++; if (rx_valid !== 1'b0) $display("FAIL timing_early got valid=%b want 0", rx_valid); else n_pass++;
            end
            if (t == LAT) begin
                n_checks++; if (rx_valid !== 1'b1) $display("FAIL timing_valid got %b want 1", rx_valid); else n_pass++;
                n_checks++; if (rx_data !== 9'h0A5) $display("FAIL timing_data got %h want 0a5", rx_data); else n_pass++;
            end
        end
        hold_line(1'b1, 16);
        n_checks++;
        if (got_q.size() - rd !== exp_q.size()) $display("FAIL timing_count got %0d want %0d", got_q.size() - rd, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && rd + i < got_q.size(); i++) begin
            n_checks++; if (got_q[rd+i] !== exp_q[i]) $display("FAIL timing_word got %h want %h", got_q[rd+i], exp_q[i]); else n_pass++;
        end
        rd = got_q.size(); exp_q.delete();
    endtask

    task automatic test_parity_framing();
        send_frame(1'b0, 2'b01, 1'b0, 9'h003, 1'b1, 1'b1, 1'b1, 32, 1'b0, -1);
        send_frame(1'b0, 2'b10, 1'b0, 9'h003, 1'b1, 1'b1, 1'b1, 32, 1'b0, -1);
        send_frame(1'b0, 2'b01, 1'b1, 9'h0C1, 1'b1, 1'b1, 1'b1, 32, 1'b0, -1);
        send_frame(1'b0, 2'b00, 1'b0, 9'h05A, 1'b0, 1'b0, 1'b1, 32, 1'b0, -1);
        send_frame(1'b0, 2'b00, 1'b0, 9'h011, 1'b0, 1'b1, 1'b1, 32, 1'b0, -1);
        send_frame(1'b1, 2'b00, 1'b1, 9'h077, 1'b0, 1'b1, 1'b0, 16, 1'b0, -1);
        n_checks++;
        if (got_q.size() - rd !== exp_q.size()) $display("FAIL parity_framing_count got %0d want %0d", got_q.size() - rd, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && rd + i < got_q.size(); i++) begin
            n_checks++; if (got_q[rd+i] !== exp_q[i]) $display("FAIL parity_framing_word%0d got %h want %h", i, got_q[rd+i], exp_q[i]); else n_pass++;
        end
        rd = got_q.size(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        send_frame(1'b1, 2'b11, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b1, 0, 1'b0, -1);
        send_frame(1'b1, 2'b11, 1'b1, 9'h100, 1'b0, 1'b1, 1'b1, 0, 1'b0, -1);
        send_frame(1'b1, 2'b11, 1'b1, 9'h0AA, 1'b0, 1'b1, 1'b1, 12, 1'b0, -1);
        n_checks++;
        if (got_q.size() - rd !== exp_q.size()) $display("FAIL b2b_count got %0d want %0d", got_q.size() - rd, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && rd + i < got_q.size(); i++) begin
            n_checks++; if (got_q[rd+i] !== exp_q[i]) $display("FAIL b2b_word%0d got %h want %h", i, got_q[rd+i], exp_q[i]); else n_pass++;
        end
        rd = got_q.size(); exp_q.delete();
    endtask

    task automatic test_overrun();
        int base;
        base  = ovr_cnt;
        ready = 1'b0;
        send_frame(1'b0, 2'b00, 1'b0, 9'h012, 1'b0, 1'b1, 1'b1, 8, 1'b0, -1);
        send_frame(1'b0, 2'b00, 1'b0, 9'h034, 1'b0, 1'b1, 1'b1, 8, 1'b0, -1);
        void'(exp_q.pop_back());
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL overrun_valid got %b want 1", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 9'h012) $display("FAIL overrun_hold got %h want 012", rx_data); else n_pass++;
        n_checks++; if (ovr_cnt - base !== 1) $display("FAIL overrun_pulses got %0d want 1", ovr_cnt - base); else n_pass++;
        ready = 1'b1;
        hold_line(1'b1, 4);
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL overrun_drain got valid=%b want 0", rx_valid); else n_pass++;
        n_checks++;
        if (got_q.size() - rd !== exp_q.size()) $display("FAIL overrun_count got %0d want %0d", got_q.size() - rd, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && rd + i < got_q.size(); i++) begin
            n_checks++; if (got_q[rd+i] !== exp_q[i]) $display("FAIL overrun_word got %h want %h", got_q[rd+i], exp_q[i]); else n_pass++;
        end
        rd = got_q.size(); exp_q.delete();
    endtask

    task automatic test_false_start_break();
        brgh = 1'b0; pdsel = 2'b00; stsel = 1'b0;
        hold_line(1'b0, 3);
        n_checks++; if (busy !== 1'b1) $display("FAIL false_start_busy got %b want 1", busy); else n_pass++;
        hold_line(1'b1, 16);
        n_checks++; if (busy !== 1'b0) $display("FAIL false_start_idle got %b want 0", busy); else n_pass++;
        hold_line(1'b0, 200);
        n_checks++; if (busy !== 1'b0) $display("FAIL break_no_recapture got busy=%b want 0", busy); else n_pass++;
        exp_q.push_back({9'h000, 1'b0, 1'b1});
        hold_line(1'b1, 20);
        n_checks++;
        if (got_q.size() - rd !== exp_q.size()) $display("FAIL break_count got %0d want %0d", got_q.size() - rd, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && rd + i < got_q.size(); i++) begin
            n_checks++; if (got_q[rd+i] !== exp_q[i]) $display("FAIL break_word got %h want %h", got_q[rd+i], exp_q[i]); else n_pass++;
        end
        rd = got_q.size(); exp_q.delete();
    endtask

    task automatic test_enable();
        ready = 1'b0;
        send_frame(1'b0, 2'b00, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b1, 4, 1'b0, -1);
        void'(exp_q.pop_back());
        hold_line(1'b0, 20);
        n_checks++; if (busy !== 1'b1) $display("FAIL enable_busy got %b want 1", busy); else n_pass++;
        en  = 1'b0;
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL enable_abort got busy=%b want 0", busy); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL enable_valid got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 9'h03C) $display("FAIL enable_data_kept got %h want 03c", rx_data); else n_pass++;
        en    = 1'b1;
        ready = 1'b1;
        hold_line(1'b1, 40);
        n_checks++;
        if (got_q.size() - rd !== exp_q.size()) $display("FAIL enable_count got %0d want %0d", got_q.size() - rd, exp_q.size()); else n_pass++;
        rd = got_q.size(); exp_q.delete();
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        send_frame(1'b0, 2'b00, 1'b0, 9'h0FF, 1'b0, 1'b1, 1'b1, 32, 1'b0, 8 + 16*3);
        n_checks++;
        if (got_q.size() - rd !== exp_q.size()) $display("FAIL majority_count got %0d want %0d", got_q.size() - rd, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && rd + i < got_q.size(); i++) begin
            n_checks++; if (got_q[rd+i] !== exp_q[i]) $display("FAIL majority_word got %h want %h", got_q[rd+i], exp_q[i]); else n_pass++;
        end
        rd = got_q.size(); exp_q.delete();
    endtask
`endif

    task automatic test_random();
        logic       br, st, pb, s1, s2;
        logic [1:0] pd;
        logic [8:0] w;
        int         base;
        base = ovr_cnt;
        for (int k = 0; k < 24; k++) begin
            br = 1'($urandom_range(0, 1));
            pd = 2'($urandom_range(0, 3));
            st = 1'($urandom_range(0, 1));
            w  = 9'($urandom);
            pb = 1'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 7) != 0);
            s2 = ($urandom_range(0, 7) != 0);
            send_frame(br, pd, st, w, pb, s1, s2, br ? 10 : 34, 1'b1, -1);
        end
        n_checks++; if (ovr_cnt - base !== 0) $display("FAIL random_overrun got %0d want 0", ovr_cnt - base); else n_pass++;
        n_checks++;
        if (got_q.size() - rd !== exp_q.size()) $display("FAIL random_count got %0d want %0d", got_q.size() - rd, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && rd + i < got_q.size(); i++) begin
            n_checks++; if (got_q[rd+i] !== exp_q[i]) $display("FAIL random_word%0d got %h want %h", i, got_q[rd+i], exp_q[i]); else n_pass++;
        end
        rd = got_q.size(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_timing();
        test_parity_framing();
        test_back_to_back();
        test_overrun();
        test_false_start_break();
        test_enable();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
